// File: rtl/next_address_unit_if.sv
// ============================================================================
// Module      : next_address_unit_if
// Description : Decode-control and fetch-address bundle between the decoder
//               and the next-address unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface next_address_unit_if #(
   parameter int ADDR_W = 16
);
   logic              stall;
   logic              instrValid;
   logic              isBranch;
   logic              brTrue;
   logic              isJump;
   logic              isCall;
   logic              isRet;
   logic              isHalt;
   logic [7:0]        offset;
   logic [ADDR_W-1:0] jumpAddr;
   logic [ADDR_W-1:0] pc;
   logic              pcValid;
   logic              flush;
   logic              rasEmpty;
   logic              rasFull;
   logic              rasError;

   modport master (
      output stall, instrValid, isBranch, brTrue, isJump, isCall, isRet, isHalt,
             offset, jumpAddr,
      input  pc, pcValid, flush, rasEmpty, rasFull, rasError
   );

   modport slave (
      input  stall, instrValid, isBranch, brTrue, isJump, isCall, isRet, isHalt,
             offset, jumpAddr,
      output pc, pcValid, flush, rasEmpty, rasFull, rasError
   );
endinterface

`default_nettype wire

// File: rtl/next_address_unit.sv
// ============================================================================
// Module      : next_address_unit
// Description : Program-counter sequencer with branch/jump/call/return and a
//               circular return-address stack.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module next_address_unit #(
   parameter int                ADDR_W       = 16,
   parameter int                RAS_DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   next_address_unit_if.slave bus
);

   localparam int c_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int c_CNT_W = $clog2(RAS_DEPTH + 1);

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_nextState;
   logic [ADDR_W-1:0]   r_pc;
   logic [ADDR_W-1:0]   w_nextPc;
   logic                r_flush;
   logic                w_redirect;
   logic [ADDR_W-1:0]   r_ras [RAS_DEPTH];
   logic [c_PTR_W-1:0]  r_ptr;
   logic [c_CNT_W-1:0]  r_count;
   logic                r_rasError;
   logic                w_push;
   logic                w_pop;
   logic                w_rasErrSet;
   logic                w_rasEmpty;
   logic                w_rasFull;
   logic [c_PTR_W-1:0]  w_ptrDec;
   logic [ADDR_W-1:0]   w_pcPlus1;
   logic [ADDR_W-1:0]   w_brTarget;

   assign w_pcPlus1  = r_pc + ADDR_W'(1);
   assign w_brTarget = w_pcPlus1 + {{(ADDR_W-8){bus.offset[7]}}, bus.offset};
   assign w_ptrDec   = r_ptr - c_PTR_W'(1);
   assign w_rasEmpty = (r_count == '0);
   assign w_rasFull  = (r_count == c_CNT_W'(RAS_DEPTH));

   always_comb begin
      w_nextState = r_state;
      w_nextPc    = r_pc;
      w_redirect  = 1'b0;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      w_rasErrSet = 1'b0;
      unique case (r_state)
         BOOT: w_nextState = RUN;
         RUN: begin
            if (!bus.stall) begin
               w_nextPc = w_pcPlus1;
               if (bus.instrValid) begin
                  if (bus.isHalt) begin
                     w_nextState = HALTED;
                     w_nextPc    = r_pc;
                  end else if (bus.isRet) begin
                     w_redirect = 1'b1;
                     // Underflow falls through to the sequential pc+1
                     if (w_rasEmpty) begin
                        w_rasErrSet = 1'b1;
                     end else begin
                        w_pop    = 1'b1;
                        w_nextPc = r_ras[w_ptrDec];
                     end
                  end else if (bus.isCall) begin
                     w_redirect  = 1'b1;
                     w_push      = 1'b1;
                     w_rasErrSet = w_rasFull;
                     w_nextPc    = bus.jumpAddr;
                  end else if (bus.isJump) begin
                     w_redirect = 1'b1;
                     w_nextPc   = bus.jumpAddr;
                  end else if (bus.isBranch && bus.brTrue) begin
                     w_redirect = 1'b1;
                     w_nextPc   = w_brTarget;
                  end
               end
            end
         end
         HALTED: w_nextState = HALTED;
         default: w_nextState = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= BOOT;
         r_pc       <= RESET_VECTOR;
         r_flush    <= 1'b0;
         r_ptr      <= '0;
         r_count    <= '0;
         r_rasError <= 1'b0;
      end else begin
         r_state    <= w_nextState;
         r_pc       <= w_nextPc;
         r_flush    <= w_redirect;
         r_rasError <= r_rasError | w_rasErrSet;
         // A push on a full stack wraps the pointer onto the oldest entry
         if (w_push) begin
            r_ptr <= r_ptr + c_PTR_W'(1);
            if (!w_rasFull) begin
               r_count <= r_count + c_CNT_W'(1);
            end
         end else if (w_pop) begin
            r_ptr   <= w_ptrDec;
            r_count <= r_count - c_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_ras[r_ptr] <= w_pcPlus1;
      end
   end

   assign bus.pc       = r_pc;
   assign bus.pcValid  = (r_state == RUN);
   assign bus.flush    = r_flush;
   assign bus.rasEmpty = w_rasEmpty;
   assign bus.rasFull  = w_rasFull;
   assign bus.rasError = r_rasError;

endmodule

`default_nettype wire

// File: tb/tb_next_address_unit.sv
// ============================================================================
// Module      : tb_next_address_unit
// Description : Directed self-checking bench for next_address_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_next_address_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   passCnt = 0;
   int   totalCnt = 0;

   next_address_unit_if #(.ADDR_W(16)) bus ();

   next_address_unit #(
      .ADDR_W       (16),
      .RAS_DEPTH    (4),
      .RESET_VECTOR (16'h0000)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.stall      = 1'b0;
      bus.instrValid = 1'b0;
      bus.isBranch   = 1'b0;
      bus.brTrue     = 1'b0;
      bus.isJump     = 1'b0;
      bus.isCall     = 1'b0;
      bus.isRet      = 1'b0;
      bus.isHalt     = 1'b0;
      bus.offset     = 8'h00;
      bus.jumpAddr   = 16'h0000;
   endtask

   task automatic jumpTo(input logic [15:0] a);
      idle();
      bus.instrValid = 1'b1;
      bus.isJump     = 1'b1;
      bus.jumpAddr   = a;
      tick();
      idle();
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      #12;
      totalCnt++; if (bus.pc !== 16'h0000) $display("FAIL reset_pc: got %h want %h", bus.pc, 16'h0000); else passCnt++;
      totalCnt++; if ({bus.pcValid, bus.flush, bus.rasEmpty, bus.rasFull, bus.rasError} !== 5'b00100)
         $display("FAIL reset_flags: got %b want %b", {bus.pcValid, bus.flush, bus.rasEmpty, bus.rasFull, bus.rasError}, 5'b00100);
      else passCnt++;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      totalCnt++; if (bus.pcValid !== 1'b0) $display("FAIL boot_pcValid: got %b want 0", bus.pcValid); else passCnt++;
      tick();
      totalCnt++; if ({bus.pcValid, bus.pc} !== {1'b1, 16'h0000}) $display("FAIL run_pc0: got %b/%h want 1/0000", bus.pcValid, bus.pc); else passCnt++;
      tick();
      totalCnt++; if (bus.pc !== 16'h0001) $display("FAIL run_pc1: got %h want 0001", bus.pc); else passCnt++;
      tick();
      totalCnt++; if (bus.pc !== 16'h0002) $display("FAIL run_pc2: got %h want 0002", bus.pc); else passCnt++;
   endtask

   task automatic test_branch();
      jumpTo(16'h0010);
      totalCnt++; if ({bus.pc, bus.flush} !== {16'h0010, 1'b1}) $display("FAIL jump_0010: got %h/%b want 0010/1", bus.pc, bus.flush); else passCnt++;
      bus.instrValid = 1'b1; bus.isBranch = 1'b1; bus.brTrue = 1'b1; bus.offset = 8'hF8;
      tick(); idle();
      totalCnt++; if ({bus.pc, bus.flush} !== {16'h0009, 1'b1}) $display("FAIL br_taken: got %h/%b want 0009/1", bus.pc, bus.flush); else passCnt++;
      tick();
      totalCnt++; if ({bus.pc, bus.flush} !== {16'h000A, 1'b0}) $display("FAIL br_after: got %h/%b want 000a/0", bus.pc, bus.flush); else passCnt++;
      jumpTo(16'h0010);
      bus.instrValid = 1'b1; bus.isBranch = 1'b1; bus.brTrue = 1'b0; bus.offset = 8'hF8;
      tick(); idle();
      totalCnt++; if ({bus.pc, bus.flush} !== {16'h0011, 1'b0}) $display("FAIL br_not_taken: got %h/%b want 0011/0", bus.pc, bus.flush); else passCnt++;
      // Ignored controls with instrValid low still advance sequentially
      bus.isJump = 1'b1; bus.jumpAddr = 16'h0777;
      tick(); idle();
      totalCnt++; if (bus.pc !== 16'h0012) $display("FAIL invalid_ignored: got %h want 0012", bus.pc); else passCnt++;
   endtask

   task automatic test_wrap();
      jumpTo(16'hFFFF);
      tick();
      totalCnt++; if (bus.pc !== 16'h0000) $display("FAIL seq_wrap: got %h want 0000", bus.pc); else passCnt++;
      jumpTo(16'hFFFE);
      bus.instrValid = 1'b1; bus.isBranch = 1'b1; bus.brTrue = 1'b1; bus.offset = 8'h05;
      tick(); idle();
      totalCnt++; if (bus.pc !== 16'h0004) $display("FAIL br_wrap: got %h want 0004", bus.pc); else passCnt++;
   endtask

   task automatic test_call_ret();
      jumpTo(16'h0040);
      bus.instrValid = 1'b1; bus.isCall = 1'b1; bus.jumpAddr = 16'h0200;
      tick(); idle();
      totalCnt++; if ({bus.pc, bus.flush, bus.rasEmpty} !== {16'h0200, 2'b10}) $display("FAIL call: got %h/%b/%b want 0200/1/0", bus.pc, bus.flush, bus.rasEmpty); else passCnt++;
      bus.instrValid = 1'b1; bus.isRet = 1'b1;
      tick(); idle();
      totalCnt++; if ({bus.pc, bus.flush, bus.rasEmpty} !== {16'h0041, 2'b11}) $display("FAIL ret: got %h/%b/%b want 0041/1/1", bus.pc, bus.flush, bus.rasEmpty); else passCnt++;
      tick();
      totalCnt++; if ({bus.pc, bus.flush, bus.rasError} !== {16'h0042, 2'b00}) $display("FAIL after_ret: got %h/%b/%b want 0042/0/0", bus.pc, bus.flush, bus.rasError); else passCnt++;
   endtask

   task automatic test_priority();
      jumpTo(16'h0500);
      bus.instrValid = 1'b1; bus.isCall = 1'b1; bus.isJump = 1'b1; bus.isBranch = 1'b1;
      bus.brTrue = 1'b1; bus.offset = 8'h10; bus.jumpAddr = 16'h0700;
      tick(); idle();
      totalCnt++; if ({bus.pc, bus.rasEmpty} !== {16'h0700, 1'b0}) $display("FAIL prio_call: got %h/%b want 0700/0", bus.pc, bus.rasEmpty); else passCnt++;
      bus.instrValid = 1'b1; bus.isRet = 1'b1; bus.isCall = 1'b1; bus.jumpAddr = 16'h0900;
      tick(); idle();
      totalCnt++; if ({bus.pc, bus.rasEmpty} !== {16'h0501, 1'b1}) $display("FAIL prio_ret: got %h/%b want 0501/1", bus.pc, bus.rasEmpty); else passCnt++;
      jumpTo(16'h0600);
      bus.instrValid = 1'b1; bus.isJump = 1'b1; bus.isBranch = 1'b1; bus.brTrue = 1'b1;
      bus.offset = 8'h10; bus.jumpAddr = 16'h0800;
      tick(); idle();
      totalCnt++; if (bus.pc !== 16'h0800) $display("FAIL prio_jump: got %h want 0800", bus.pc); else passCnt++;
   endtask

   task automatic test_overflow();
      logic [15:0] expRet [4];
      expRet[0] = 16'h0501; expRet[1] = 16'h0401; expRet[2] = 16'h0301; expRet[3] = 16'h0201;
      jumpTo(16'h0100);
      for (int i = 0; i < 5; i++) begin
         bus.instrValid = 1'b1; bus.isCall = 1'b1; bus.jumpAddr = 16'((i + 2) * 256);
         tick(); idle();
         if (i == 3) begin
            totalCnt++; if ({bus.rasFull, bus.rasError} !== 2'b10) $display("FAIL full_no_err: got %b want 10", {bus.rasFull, bus.rasError}); else passCnt++;
         end
      end
      totalCnt++; if ({bus.pc, bus.rasFull, bus.rasError} !== {16'h0600, 2'b11}) $display("FAIL overflow: got %h/%b want 0600/11", bus.pc, {bus.rasFull, bus.rasError}); else passCnt++;
      for (int i = 0; i < 4; i++) begin
         bus.instrValid = 1'b1; bus.isRet = 1'b1;
         tick(); idle();
         totalCnt++; if (bus.pc !== expRet[i]) $display("FAIL lifo_%0d: got %h want %h", i, bus.pc, expRet[i]); else passCnt++;
      end
      totalCnt++; if (bus.rasEmpty !== 1'b1) $display("FAIL drained_empty: got %b want 1", bus.rasEmpty); else passCnt++;
      bus.instrValid = 1'b1; bus.isRet = 1'b1;
      tick(); idle();
      totalCnt++; if ({bus.pc, bus.rasEmpty, bus.rasError} !== {16'h0202, 2'b11}) $display("FAIL underflow: got %h/%b want 0202/11", bus.pc, {bus.rasEmpty, bus.rasError}); else passCnt++;
      tick();
   endtask

   task automatic test_stall();
      // pc is 0x0203 here with flush low
      bus.stall = 1'b1; bus.instrValid = 1'b1; bus.isJump = 1'b1; bus.jumpAddr = 16'h1234;
      for (int i = 0; i < 3; i++) begin
         tick();
         totalCnt++; if ({bus.pc, bus.flush} !== {16'h0203, 1'b0}) $display("FAIL stall_%0d: got %h/%b want 0203/0", i, bus.pc, bus.flush); else passCnt++;
      end
      bus.stall = 1'b0;
      tick();
      totalCnt++; if ({bus.pc, bus.flush} !== {16'h1234, 1'b1}) $display("FAIL stall_release: got %h/%b want 1234/1", bus.pc, bus.flush); else passCnt++;
      bus.stall = 1'b1;
      tick();
      totalCnt++; if ({bus.pc, bus.flush} !== {16'h1234, 1'b0}) $display("FAIL stall_clears_flush: got %h/%b want 1234/0", bus.pc, bus.flush); else passCnt++;
      idle();
   endtask

   task automatic test_halt();
      jumpTo(16'h0030);
      bus.instrValid = 1'b1; bus.isHalt = 1'b1; bus.isJump = 1'b1; bus.jumpAddr = 16'h0999;
      tick(); idle();
      totalCnt++; if ({bus.pc, bus.pcValid} !== {16'h0030, 1'b0}) $display("FAIL halt: got %h/%b want 0030/0", bus.pc, bus.pcValid); else passCnt++;
      bus.instrValid = 1'b1; bus.isJump = 1'b1; bus.jumpAddr = 16'h0999;
      tick(); tick(); idle();
      totalCnt++; if ({bus.pc, bus.pcValid} !== {16'h0030, 1'b0}) $display("FAIL halt_hold: got %h/%b want 0030/0", bus.pc, bus.pcValid); else passCnt++;
      rst_n = 1'b0;
      #2;
      totalCnt++; if ({bus.pc, bus.pcValid, bus.rasError} !== {16'h0000, 2'b00}) $display("FAIL async_reset: got %h/%b/%b want 0000/0/0", bus.pc, bus.pcValid, bus.rasError); else passCnt++;
      rst_n = 1'b1;
      #1;
      totalCnt++; if (bus.pcValid !== 1'b0) $display("FAIL reboot: got %b want 0", bus.pcValid); else passCnt++;
      tick();
      totalCnt++; if ({bus.pc, bus.pcValid} !== {16'h0000, 1'b1}) $display("FAIL restart0: got %h/%b want 0000/1", bus.pc, bus.pcValid); else passCnt++;
      tick();
      totalCnt++; if (bus.pc !== 16'h0001) $display("FAIL restart1: got %h want 0001", bus.pc); else passCnt++;
   endtask

   initial begin
      test_reset();
      test_branch();
      test_wrap();
      test_call_ret();
      test_priority();
      test_overflow();
      test_stall();
      test_halt();
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/next_address_unit.md
NEXT_ADDRESS_UNIT -- requirements
Module: next_address_unit

Interface
REQ-001 Parameter ADDR_W, default 16, program counter and address width in bits.
REQ-002 Parameter RAS_DEPTH, default 4, number of return-address stack entries (power of two).
REQ-003 Parameter RESET_VECTOR, default 0, value loaded into pc on reset.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 stall  input  1  when high, all state holds.
REQ-007 instrValid  input  1  the decode controls below are valid this cycle.
REQ-008 isBranch  input  1  conditional branch; taken when brTrue=1.
REQ-009 brTrue  input  1  branch condition result from the branch decider.
REQ-010 isJump  input  1  unconditional absolute jump to jumpAddr.
REQ-011 isCall  input  1  absolute call to jumpAddr; pushes return address.
REQ-012 isRet  input  1  return; pops the return-address stack.
REQ-013 isHalt  input  1  stop fetching.
REQ-014 offset  input  8  signed two's-complement branch displacement.
REQ-015 jumpAddr  input  ADDR_W  absolute target for jump and call.
REQ-016 pc  output  ADDR_W  current fetch address (registered).
REQ-017 pcValid  output  1  pc holds a fetchable address.
REQ-018 flush  output  1  one-cycle pulse; the previous sequential fetch is squashed.
REQ-019 rasEmpty, rasFull  output  1 each  stack occupancy flags (combinational from the count).
REQ-020 rasError  output  1  sticky flag for stack overflow or underflow.

Function
REQ-021 The FSM SHALL have states BOOT, RUN and HALTED; reset enters BOOT, BOOT goes to RUN on the next edge, and pcValid is 1 only in RUN.
REQ-022 The unit accepts a command only in RUN with stall=0 and instrValid=1; otherwise the controls are ignored.
REQ-023 For an accepted command, the priority SHALL be isHalt > isRet > isCall > isJump > isBranch > sequential, and only the highest-priority command takes effect.
REQ-024 Sequential: pc <= pc+1, modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
REQ-025 Taken branch: pc <= pc + 1 + sign_extend(offset), modulo 2^ADDR_W.
REQ-026 A not-taken branch SHALL be treated as sequential.
REQ-027 Jump: pc <= jumpAddr.
REQ-028 Call: pc <= jumpAddr and push pc+1.
REQ-029 Return: pc <= top of stack and pop.
REQ-030 Halt: the FSM goes to HALTED and pc holds; HALTED is left only by reset.
REQ-031 In RUN with stall=0 and instrValid=0, pc SHALL advance sequentially.
REQ-032 The pc SHALL hold in BOOT, in HALTED and whenever stall=1.
REQ-033 flush SHALL be 1 for exactly the one cycle after an edge that accepted a taken branch, jump, call or return; it is 0 after any stall edge.
REQ-034 Zero latency on redirect: the new pc is visible the cycle after the accepting edge.
REQ-035 Call on full stack: the stack is circular, the oldest entry is overwritten, the count stays RAS_DEPTH and rasError is set.
REQ-036 Return on empty stack: pc <= pc+1, the count stays 0 and rasError is set.
REQ-037 rasError SHALL clear only on reset.
REQ-038 The stack SHALL change only on accepted call or return commands.

Reset
REQ-039 While rst_n=0, asynchronously: pc=RESET_VECTOR, state=BOOT, pcValid=0, flush=0, stack count=0, rasEmpty=1, rasFull=0, rasError=0.
REQ-040 Stack entry contents need not be reset.
REQ-041 Assertion of reset mid-operation, including during stall or HALTED, SHALL abandon all state immediately.

Verification
REQ-042 Reset release, no commands -> pcValid 0 for one cycle, then pc 0x0000, 0x0001, 0x0002 on successive cycles.
REQ-043 Branch at pc=0x0010 with brTrue=1 and offset=0xF8 (-8) -> pc=0x0009 and flush=1 for one cycle; the same with brTrue=0 -> pc=0x0011 and flush=0.
REQ-044 Call to 0x0200 at pc=0x0040, then return -> pc 0x0200 followed by 0x0041; rasEmpty ends at 1; flush pulses once after each.
REQ-045 Five calls at RAS_DEPTH=4 -> rasFull=1 and rasError=1; four returns yield the last four return addresses in LIFO order; a fifth return -> pc+1 and rasEmpty=1.
REQ-046 A jump to 0x1234 issued with stall=1 for 3 cycles -> pc and flush are unchanged while stalled, and pc=0x1234 follows the first non-stalled edge.
REQ-047 isHalt together with isJump at pc=0x0030 -> pc holds 0x0030 and pcValid=0; reset pulse -> BOOT, then pc restarts at RESET_VECTOR.
